// File: rtl/xy_scan_gen_pkg.sv
// Shared encodings for the XY scan generator: scan modes, FSM states and
// default widths.
package xy_scan_pkg;

    localparam int CW_DEF = 16;
    localparam int DW_DEF = 32;

    localparam logic [1:0] MODE_POINT  = 2'd0;
    localparam logic [1:0] MODE_RASTER = 2'd1;
    localparam logic [1:0] MODE_SERP   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC_X = 3'd1,
        ST_CALC_Y = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DWELL  = 3'd4,
        ST_DONE   = 3'd5
    } scan_state_t;

endpackage

// File: rtl/xy_scan_gen_if.sv
// Coordinate stream from the scan generator to the XY2 serializer.
// A point transfers on every clock edge where coord_valid and coord_ready are
// both high; while valid is high and ready is low, x/y are held unchanged.
interface xy_scan_gen_if #(
    parameter int CW = 16
);
    logic [CW-1:0] x_coord;
    logic [CW-1:0] y_coord;
    logic          coord_valid;
    logic          coord_ready;

    modport master (
        output x_coord,
        output y_coord,
        output coord_valid,
        input  coord_ready
    );

    modport slave (
        input  x_coord,
        input  y_coord,
        input  coord_valid,
        output coord_ready
    );
endinterface

// File: rtl/xy_scan_gen_div.sv
// Unsigned restoring divider with a fixed CW-cycle latency; the first
// iteration is taken on the start edge so done appears CW cycles later.
module scan_step_div #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic [CW-1:0] quotient,
    output logic          done
);
    localparam int CNTW = $clog2(CW + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CW);

    logic [CW-1:0]   rem_q;
    logic [CW-1:0]   quo_q;
    logic [CW-1:0]   div_q;
    logic [CNTW-1:0] cnt_q;
    logic            run_q;

    logic [CW-1:0] rem_in;
    logic [CW-1:0] quo_in;
    logic [CW-1:0] div_in;
    logic [CW:0]   rem_sh;
    logic [CW:0]   rem_diff;
    logic [CW-1:0] rem_nx;
    logic [CW-1:0] quo_nx;

    always_comb begin
        rem_in   = start ? '0 : rem_q;
        quo_in   = start ? dividend : quo_q;
        div_in   = start ? divisor : div_q;
        rem_sh   = {rem_in, quo_in[CW-1]};
        rem_diff = rem_sh - {1'b0, div_in};
        // A clear sign bit means the trial subtraction fits.
        if (!rem_diff[CW]) begin
            rem_nx = rem_diff[CW-1:0];
            quo_nx = {quo_in[CW-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[CW-1:0];
            quo_nx = {quo_in[CW-2:0], 1'b0};
        end
    end

    assign done     = run_q && (cnt_q == CNT_LAST);
    assign quotient = (div_q == '0) ? '0 : quo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            div_q <= divisor;
            cnt_q <= CNTW'(1);
            run_q <= 1'b1;
        end else if (run_q && !done) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CNTW'(1);
        end else if (done) begin
            run_q <= 1'b0;
        end
    end
endmodule

// File: rtl/xy_scan_gen.sv
// Point/raster/serpentine galvo scan generator with per-point dwell, feeding
// coordinates over a valid/ready stream.
module xy_scan_gen
    import xy_scan_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     nx,
    input  logic [CW-1:0]     ny,
    input  logic [CW-1:0]     x_min,
    input  logic [CW-1:0]     x_max,
    input  logic [CW-1:0]     y_min,
    input  logic [CW-1:0]     y_max,
    input  logic [DW-1:0]     dwell,
    xy_scan_gen_if.master     coord,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              cfg_err,
    output scan_state_t       state_dbg
);
    scan_state_t state_q, state_d;

    logic          serp_q;
    logic [CW-1:0] nx_q, ny_q;
    logic [CW-1:0] x_lo_q, x_hi_q, y_lo_q, y_hi_q;
    logic [DW-1:0] dwell_q, dwell_cnt_q;
    logic [CW-1:0] step_x_q, step_y_q;
    logic [CW:0]   x_acc_q, y_acc_q;
    logic [CW-1:0] x_idx_q, y_idx_q;
    logic          x_desc_q;
    logic          aborted_q;
    logic          cfg_err_q;

    logic          point_in, x_inv_in, y_inv_in;
    logic [CW-1:0] nx_eff_in, ny_eff_in, x_hi_in, y_hi_in;
    logic          div_start, div_done;
    logic [CW-1:0] div_dividend, div_divisor, div_quo;
    logic          go_abort, hs, row_end, last_pt, dwell_end;

    // Degenerate axes (point mode, n=0, inverted bounds) collapse to one
    // point at min, so the span and the divisor both become zero.
    always_comb begin
        point_in  = (mode != MODE_RASTER) && (mode != MODE_SERP);
        x_inv_in  = x_max < x_min;
        y_inv_in  = y_max < y_min;
        nx_eff_in = (point_in || x_inv_in || nx == '0) ? CW'(1) : nx;
        ny_eff_in = (point_in || y_inv_in || ny == '0) ? CW'(1) : ny;
        x_hi_in   = (nx_eff_in == CW'(1)) ? x_min : x_max;
        y_hi_in   = (ny_eff_in == CW'(1)) ? y_min : y_max;
    end

    always_comb begin
        if (state_q == ST_IDLE) begin
            div_dividend = x_hi_in - x_min;
            div_divisor  = nx_eff_in - CW'(1);
        end else begin
            div_dividend = y_hi_q - y_lo_q;
            div_divisor  = ny_q - CW'(1);
        end
    end

    scan_step_div #(.CW(CW)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quo),
        .done     (div_done)
    );

    assign go_abort  = abort && (state_q inside {ST_CALC_X, ST_CALC_Y, ST_EMIT, ST_DWELL});
    assign hs        = (state_q == ST_EMIT) && coord.coord_ready && !abort;
    assign row_end   = x_desc_q ? (x_idx_q == '0) : (x_idx_q == nx_q - CW'(1));
    assign last_pt   = row_end && (y_idx_q == ny_q - CW'(1));
    assign dwell_end = (dwell_cnt_q == dwell_q - DW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CALC_X;
                    div_start = 1'b1;
                end
            end
            ST_CALC_X: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (div_done) begin
                    state_d   = ST_CALC_Y;
                    div_start = 1'b1;
                end
            end
            ST_CALC_Y: begin
                if (abort)         state_d = ST_DONE;
                else if (div_done) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (coord.coord_ready) begin
                    if (last_pt)            state_d = ST_DONE;
                    else if (dwell_q == '0) state_d = ST_EMIT;
                    else                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (abort)          state_d = ST_DONE;
                else if (dwell_end) state_d = ST_EMIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serp_q      <= 1'b0;
            nx_q        <= '0;
            ny_q        <= '0;
            x_lo_q      <= '0;
            x_hi_q      <= '0;
            y_lo_q      <= '0;
            y_hi_q      <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            step_x_q    <= '0;
            step_y_q    <= '0;
            x_acc_q     <= '0;
            y_acc_q     <= '0;
            x_idx_q     <= '0;
            y_idx_q     <= '0;
            x_desc_q    <= 1'b0;
            aborted_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                serp_q    <= (mode == MODE_SERP);
                nx_q      <= nx_eff_in;
                ny_q      <= ny_eff_in;
                x_lo_q    <= x_min;
                x_hi_q    <= x_hi_in;
                y_lo_q    <= y_min;
                y_hi_q    <= y_hi_in;
                dwell_q   <= dwell;
                x_acc_q   <= {1'b0, x_min};
                y_acc_q   <= {1'b0, y_min};
                x_idx_q   <= '0;
                y_idx_q   <= '0;
                x_desc_q  <= 1'b0;
                cfg_err_q <= x_inv_in || y_inv_in;
            end
            if (state_q == ST_CALC_X && div_done) step_x_q <= div_quo;
            if (state_q == ST_CALC_Y && div_done) step_y_q <= div_quo;
            if (hs && !last_pt) begin
                if (row_end) begin
                    // Serpentine turns keep x in place and only reverse direction.
                    y_idx_q <= y_idx_q + CW'(1);
                    y_acc_q <= y_acc_q + {1'b0, step_y_q};
                    if (serp_q) begin
                        x_desc_q <= ~x_desc_q;
                    end else begin
                        x_idx_q <= '0;
                        x_acc_q <= {1'b0, x_lo_q};
                    end
                end else if (x_desc_q) begin
                    x_idx_q <= x_idx_q - CW'(1);
                    x_acc_q <= x_acc_q - {1'b0, step_x_q};
                end else begin
                    x_idx_q <= x_idx_q + CW'(1);
                    x_acc_q <= x_acc_q + {1'b0, step_x_q};
                end
            end
            if (state_q == ST_DWELL) dwell_cnt_q <= dwell_cnt_q + DW'(1);
            else                     dwell_cnt_q <= '0;
            aborted_q <= go_abort;
        end
    end

    // The last index of each axis is pinned to the bound so truncated steps
    // never leave the final point short or past the window.
    assign coord.x_coord     = (x_idx_q == nx_q - CW'(1) || x_acc_q[CW]) ? x_hi_q : x_acc_q[CW-1:0];
    assign coord.y_coord     = (y_idx_q == ny_q - CW'(1) || y_acc_q[CW]) ? y_hi_q : y_acc_q[CW-1:0];
    assign coord.coord_valid = (state_q == ST_EMIT);

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign aborted   = aborted_q;
    assign cfg_err   = cfg_err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_xy_scan_gen.sv
// Scoreboard bench for xy_scan_gen: a reference model pushes the expected
// coordinate list at start, and a monitor checks every presented point.
module tb_xy_scan_gen;
  import xy_scan_pkg::*;

  localparam int CW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] nx = '0, ny = '0;
  logic [CW-1:0] x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic [DW-1:0] dwell = '0;
  logic          busy, done, aborted, cfg_err;
  scan_state_t   state_dbg;

  xy_scan_gen_if #(.CW(CW)) cif ();

  xy_scan_gen #(.CW(CW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .nx        (nx),
    .ny        (ny),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max),
    .dwell     (dwell),
    .coord     (cif.master),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .cfg_err   (cfg_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [2*CW-1:0] exp_q[$];
  int  exp_dwell = 0;
  int  start_cyc = 0;
  bit  first_pending = 0;
  int  hs_cyc = 0;
  int  hs_cnt = 0;
  int  done_cnt = 0;
  bit  ready_rand = 0;
  bit  ready_level = 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int unsigned axis_pos(input int unsigned i, input int unsigned n,
                                           input int unsigned lo, input int unsigned hi);
    if (n == 1) return lo;
    if (i == n - 1) return hi;
    return lo + i * ((hi - lo) / (n - 1));
  endfunction

  task automatic model_push(input logic [1:0] m, input int unsigned nxi, input int unsigned nyi,
                            input int unsigned xlo, input int unsigned xhi,
                            input int unsigned ylo, input int unsigned yhi);
    bit pt;
    int unsigned nxe, nye, xi, xv, yv;
    logic [CW-1:0] xs, ys;
    pt  = (m != 2'd1) && (m != 2'd2);
    nxe = (pt || nxi == 0 || xhi < xlo) ? 1 : nxi;
    nye = (pt || nyi == 0 || yhi < ylo) ? 1 : nyi;
    for (int r = 0; r < int'(nye); r++) begin
      yv = axis_pos(r, nye, ylo, yhi);
      for (int k = 0; k < int'(nxe); k++) begin
        xi = (m == 2'd2 && (r % 2) == 1) ? nxe - 1 - k : k;
        xv = axis_pos(xi, nxe, xlo, xhi);
        xs = xv[CW-1:0];
        ys = yv[CW-1:0];
        exp_q.push_back({xs, ys});
      end
    end
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    cif.coord_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cif.coord_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_level;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit prev_valid;
    bit prev_hs;
    prev_valid = 0;
    prev_hs = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 0;
        prev_hs = 0;
      end else begin
        if (done) done_cnt++;
        if (cif.coord_valid) begin
          if (!prev_valid || prev_hs) begin
            if (first_pending) begin
              chk("start_latency", cyc - start_cyc, 2 * CW + 1);
              first_pending = 0;
            end else begin
              chk("dwell_gap", cyc - hs_cyc, exp_dwell + 1);
            end
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_coord: got x=%0d y=%0d, expected queue empty", cif.x_coord, cif.y_coord);
          end else begin
            chk("coord_xy", {cif.x_coord, cif.y_coord}, exp_q[0]);
            if (cif.coord_ready) void'(exp_q.pop_front());
          end
          if (cif.coord_ready) begin
            hs_cyc = cyc;
            hs_cnt++;
          end
          prev_hs = cif.coord_ready;
        end else begin
          prev_hs = 0;
        end
        prev_valid = cif.coord_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_scan(input logic [1:0] m, input int unsigned nxi, input int unsigned nyi,
                            input int unsigned xlo, input int unsigned xhi,
                            input int unsigned ylo, input int unsigned yhi, input int unsigned dw);
    @(posedge clk);
    #1;
    mode  = m;
    nx    = CW'(nxi);
    ny    = CW'(nyi);
    x_min = CW'(xlo);
    x_max = CW'(xhi);
    y_min = CW'(ylo);
    y_max = CW'(yhi);
    dwell = DW'(dw);
    model_push(m, nxi, nyi, xlo, xhi, ylo, yhi);
    exp_dwell = int'(dw);
    start = 1'b1;
    start_cyc = cyc;
    first_pending = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Config inputs must be ignored once the scan is running.
    mode  = 2'($urandom);
    nx    = CW'($urandom);
    ny    = CW'($urandom);
    x_min = CW'($urandom);
    x_max = CW'($urandom);
    y_min = CW'($urandom);
    y_max = CW'($urandom);
    dwell = DW'($urandom_range(0, 7));
    #1;
    chk("busy_after_start", busy, 1);
    chk("no_valid_while_calc", cif.coord_valid, 0);
  endtask

  task automatic wait_done(input bit exp_cfg_err);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!done && n < 5000);
    if (!done) begin
      fail_now("done_timeout");
    end else begin
      chk("queue_drained", exp_q.size(), 0);
      chk("aborted_low_on_done", aborted, 0);
      chk("busy_low_on_done", busy, 0);
      chk("cfg_err", cfg_err, exp_cfg_err);
      @(posedge clk);
      #2;
      chk("done_one_cycle", done, 0);
    end
    exp_q.delete();
  endtask

  task automatic wait_hs(input int target, input string name);
    int n;
    n = 0;
    while (hs_cnt < target && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (hs_cnt < target) fail_now(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hs0, n;
    int unsigned xlo, xhi, ylo, yhi;
    logic [1:0] m;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_valid", cif.coord_valid, 0);
    chk("rst_xy", {cif.x_coord, cif.y_coord}, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Point mode: a single (x_min, y_min).
    ready_level = 1;
    hs0 = hs_cnt;
    start_scan(2'd0, 5, 5, 100, 300, 200, 400, 0);
    wait_done(0);
    chk("point_count", hs_cnt - hs0, 1);

    // Raster with a truncated step and clamped last column.
    hs0 = hs_cnt;
    start_scan(2'd1, 4, 2, 0, 10, 0, 7, 0);
    wait_done(0);
    chk("raster_count", hs_cnt - hs0, 8);

    // Serpentine 3x3.
    hs0 = hs_cnt;
    start_scan(2'd2, 3, 3, 0, 10, 0, 20, 0);
    wait_done(0);
    chk("serp_count", hs_cnt - hs0, 9);

    // Backpressure on point 2 with dwell 5.
    hs0 = hs_cnt;
    start_scan(2'd1, 3, 2, 0, 40, 0, 9, 5);
    wait_hs(hs0 + 1, "bp_first_hs");
    ready_level = 0;
    n = 0;
    while (!cif.coord_valid && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("bp_valid_held", cif.coord_valid, 1);
    chk("bp_no_extra_hs", hs_cnt - hs0, 1);
    ready_level = 1;
    wait_done(0);
    chk("bp_count", hs_cnt - hs0, 6);

    // Abort on the 3rd point of a 4x4 raster, then restart.
    hs0 = hs_cnt;
    start_scan(2'd1, 4, 4, 0, 30, 0, 30, 3);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(cif.coord_valid && hs_cnt == hs0 + 2) && n < 1000);
    if (n >= 1000) fail_now("abort_wait_third");
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    chk("abort_valid_low", cif.coord_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_aborted", aborted, 1);
    chk("abort_busy_low", busy, 0);
    @(posedge clk);
    #2;
    chk("abort_done_pulse", done, 0);
    chk("abort_aborted_pulse", aborted, 0);
    chk("abort_state_idle", state_dbg, ST_IDLE);
    exp_q.delete();
    start_scan(2'd1, 2, 2, 7, 17, 3, 13, 1);
    wait_done(0);

    // Inverted x bounds with nx=0: x pinned at 9, two rows.
    hs0 = hs_cnt;
    start_scan(2'd1, 0, 2, 9, 5, 0, 30, 0);
    wait_done(1);
    chk("cfg_err_count", hs_cnt - hs0, 2);

    // Randomized scans with random backpressure.
    ready_rand = 1;
    for (int t = 0; t < 12; t++) begin
      m   = 2'($urandom_range(0, 3));
      xlo = $urandom_range(0, 60000);
      ylo = $urandom_range(0, 60000);
      xhi = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 65535) : xlo + $urandom_range(0, 65535 - xlo);
      yhi = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 65535) : ylo + $urandom_range(0, 65535 - ylo);
      hs0 = hs_cnt;
      start_scan(m, $urandom_range(0, 6), $urandom_range(0, 4), xlo, xhi, ylo, yhi, $urandom_range(0, 3));
      wait_done((xhi < xlo) || (yhi < ylo));
    end
    ready_rand = 0;
    ready_level = 1;

    // Asynchronous reset in the middle of a dwell.
    start_scan(2'd1, 3, 2, 0, 30, 8, 2, 20);
    n = 0;
    while (state_dbg != ST_DWELL && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (state_dbg != ST_DWELL) fail_now("reset_wait_dwell");
    chk("pre_reset_cfg_err", cfg_err, 1);
    hs0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cfg_err", cfg_err, 0);
    chk("mid_rst_valid", cif.coord_valid, 0);
    chk("mid_rst_xy", {cif.x_coord, cif.y_coord}, 0);
    chk("mid_rst_state", state_dbg, ST_IDLE);
    exp_q.delete();
    first_pending = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("no_done_after_reset", done_cnt - hs0, 0);
    chk("post_reset_idle", state_dbg, ST_IDLE);

    // Recovery after reset.
    hs0 = hs_cnt;
    start_scan(2'd3, 4, 4, 55, 99, 66, 77, 2);
    wait_done(0);
    chk("recover_count", hs_cnt - hs0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
